reset_seq: RTL and testbench
============================

Name: reset_seq

Overview:
- Synthesizable reset sequencer for the clock FPGA.
- Holds all downstream block resets asserted until the reference PLL lock is stable, then releases NUM_STAGES reset outputs in a fixed order.
- Each release is followed by waiting for that stage's init_done acknowledgement, with a timeout per stage.
- Replaces ad-hoc per-block reset release; sits directly after the board reset input, ahead of the timekeeping, PPS and NTP datapaths.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs, range 1..8.
- STAGE_DLY, 1000: clk cycles from entering DELAY to release of the current stage; must be >= 1.
- TIMEOUT, 50000: maximum clk cycles to wait for init_done of the released stage; must be >= 1.
- CNT_W, 16: counter width. Elaboration-time check: 2**CNT_W > max(STAGE_DLY, TIMEOUT).

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: asynchronous active-high reset.
- lock, input, 1: PLL lock, asynchronous. Synchronized internally by a 2-flop synchronizer.
- sw_rst, input, 1: synchronous single-cycle request to rerun the sequence.
- init_done, input, NUM_STAGES: per-stage ready, synchronous to clk.
- stage_rst, output, NUM_STAGES: active-high reset to each stage, registered.
- stage_idx, output, 3: index of the stage currently being sequenced.
- seq_done, output, 1: high while all stages are released and running.
- timeout_err, output, 1: sticky error flag.

Behaviour:
- Reset is one clock; rst is asynchronous and active-high.
- rst asserted (async) forces:
  - stage_rst = all ones
  - seq_done = 0
  - timeout_err = 0
  - stage_idx = 0
  - state = WAIT_LOCK
  - counter = 0
  - both synchronizer flops = 0
- States: WAIT_LOCK, DELAY, WAIT_DONE, RUN, ERR.
- WAIT_LOCK:
  - stage_rst all ones, stage_idx = 0.
  - On an edge with lock_s = 1, go to DELAY and load counter = STAGE_DLY-1.
- DELAY:
  - Counter decrements each edge.
  - On the edge where counter == 0:
    - clear stage_rst[stage_idx]
    - load counter = TIMEOUT-1
    - go to WAIT_DONE
  - stage_rst[k] therefore falls exactly STAGE_DLY edges after the edge that entered DELAY.
- WAIT_DONE:
  - Samples init_done[stage_idx] each edge.
  - If high:
    - if stage_idx == NUM_STAGES-1, go to RUN and set seq_done = 1 on the same edge;
    - else increment stage_idx, load counter = STAGE_DLY-1 and go to DELAY.
  - If low and counter == 0: go to ERR.
  - Otherwise decrement the counter.
  - init_done already high on entry advances on the first WAIT_DONE edge.
  - init_done high on the same edge as expiry: done wins.
- RUN:
  - stage_rst all zeros, seq_done = 1.
  - init_done is ignored from here on.
- ERR:
  - stage_rst all ones, seq_done = 0, timeout_err = 1 (sticky).
  - stage_idx frozen at the failing stage.
  - Exits only via rst or sw_rst.
- Loss of lock_s in DELAY, WAIT_DONE or RUN:
  - next edge sets stage_rst all ones, seq_done = 0, stage_idx = 0, state = WAIT_LOCK;
  - timeout_err is not changed.
- Loss of lock_s in ERR is ignored.
- sw_rst in any state:
  - next edge does the same as lock loss and also clears timeout_err;
  - if lock_s is still high, the sequence restarts through WAIT_LOCK, so DELAY is entered one edge later.
- Priority: rst > lock loss > sw_rst > normal transitions.
- Stages are released strictly in ascending index order. A stage is never released before all lower-index stages are released.
- Lock latency: raw lock must be stable for 2 edges before lock_s = 1. A lock glitch shorter than one clk period may or may not be seen; either outcome is legal.

Decomposition:
- reset_seq_pkg holds:
  - typedef enum logic [2:0] state_t {WAIT_LOCK, DELAY, WAIT_DONE, RUN, ERR};
  - function clog2-based width check helper.
- Sub-module bit_sync: 2-flop synchronizer with async active-high reset to 0, used for lock.
- The FSM and counter stay in reset_seq.

Test Plan:
- Nominal run: NUM_STAGES=4, STAGE_DLY=4, TIMEOUT=10.
  - Stimulus: lock rises before edge E0; each init_done[k] rises 2 edges after stage_rst[k] falls.
  - Required: lock_s high after E1, DELAY entered at E2, stage_rst[0] falls at E6.
  - Required: stage_rst = 4'b1110, 4'b1100, 4'b1000, 4'b0000 in order; seq_done rises on the same edge stage_rst[3] falls... no: on the edge init_done[3] is sampled high.
- Timeout: init_done[2] held low.
  - Required: ERR entered exactly 10 WAIT_DONE edges after stage_rst[2] falls.
  - Required: stage_rst = 4'b1111, timeout_err = 1, stage_idx = 2.
  - Required: the state persists with lock toggling.
- Done/timeout coincidence: init_done[1] rises on the 10th WAIT_DONE edge.
  - Required: advance to stage 2, timeout_err stays 0.
- Lock loss in RUN: drop lock for 5 cycles.
  - Required: 2 edges later stage_rst = 4'b1111 and seq_done = 0.
  - Required: after lock returns, the full sequence repeats with identical timing.
- sw_rst from ERR: single-cycle pulse.
  - Required: timeout_err clears next edge.
  - Required: with lock high, DELAY is entered 2 edges after the pulse and stage_rst[0] falls 4 edges later.
- Async rst mid-DELAY of stage 2, asserted between edges.
  - Required: stage_rst goes to 4'b1111 immediately without waiting for an edge; all flags clear.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   state_t        - sequencer FSM states
//   cnt_width_ok() - checks that a CNT_W-bit counter can hold the largest
//                    load value used by the sequencer
// ---------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        DELAY,
        WAIT_DONE,
        RUN,
        ERR
    } state_t;

    // 2**cnt_w > max(stage_dly, timeout) is the same as
    // $clog2(max + 1) <= cnt_w, which avoids overflowing 2**cnt_w.
    function automatic bit cnt_width_ok(input int cnt_w,
                                        input int stage_dly,
                                        input int timeout);
        int m;
        m = (stage_dly > timeout) ? stage_dly : timeout;
        return ($clog2(m + 1) <= cnt_w);
    endfunction

endpackage

// File: rtl/reset_seq_bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both flops to 0
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq
// Reset sequencer: keeps every downstream reset asserted until the PLL lock
// is stable, then releases the stages one at a time in ascending order. Each
// release waits STAGE_DLY cycles and is then acknowledged through that
// stage's init_done within TIMEOUT cycles, otherwise the sequencer parks in
// a sticky error state.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   lock        - PLL lock, asynchronous (synchronized internally)
//   sw_rst      - single-cycle request to rerun the sequence
//   init_done   - per-stage ready acknowledgement, synchronous to clk
//   stage_rst   - registered active-high reset to each stage
//   stage_idx   - stage currently being sequenced
//   seq_done    - high while every stage is released and running
//   timeout_err - sticky flag, set when a stage fails to acknowledge
// ---------------------------------------------------------------------------
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_DLY  = 1000,
    parameter int TIMEOUT    = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    input  logic                  sw_rst,
    input  logic [NUM_STAGES-1:0] init_done,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [2:0]            stage_idx,
    output logic                  seq_done,
    output logic                  timeout_err
);

    localparam logic [NUM_STAGES-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0]      DLY_LOAD = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0]      TMO_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]            LAST_IDX = 3'(NUM_STAGES - 1);

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
            $error("reset_seq: NUM_STAGES must be in 1..8");
        end
        if (STAGE_DLY < 1 || TIMEOUT < 1) begin : g_bad_delays
            $error("reset_seq: STAGE_DLY and TIMEOUT must be >= 1");
        end
        if (!cnt_width_ok(CNT_W, STAGE_DLY, TIMEOUT)) begin : g_bad_cnt_w
            $error("reset_seq: CNT_W too small for STAGE_DLY/TIMEOUT");
        end
    endgenerate

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_STAGES-1:0]   r_stage_rst;
    logic [2:0]              r_stage_idx;
    logic                    r_seq_done;
    logic                    r_timeout_err;

    state_t                  w_state;
    logic [CNT_W-1:0]        w_cnt;
    logic [NUM_STAGES-1:0]   w_stage_rst;
    logic [2:0]              w_stage_idx;
    logic                    w_seq_done;
    logic                    w_timeout_err;

    logic                    w_lock_s;
    logic                    w_lock_lost;
    logic                    w_done_sel;
    logic [NUM_STAGES-1:0]   w_idx_mask;

    bit_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (lock),
        .o_q (w_lock_s)
    );

    // Select init_done and build a one-hot mask for the current stage by
    // comparison so the 3-bit index never has to match the vector width.
    always_comb begin
        w_done_sel = 1'b0;
        w_idx_mask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_stage_idx == 3'(k)) begin
                w_done_sel    = init_done[k];
                w_idx_mask[k] = 1'b1;
            end
        end
    end

    // Lock loss only matters once the sequence has started; in ERR it is
    // ignored so the failing stage index stays visible.
    assign w_lock_lost = !w_lock_s &&
                         (r_state == DELAY || r_state == WAIT_DONE || r_state == RUN);

    // Next-state logic. Lock loss beats sw_rst; both restart from WAIT_LOCK,
    // but only sw_rst clears the sticky error.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_stage_rst   = r_stage_rst;
        w_stage_idx   = r_stage_idx;
        w_seq_done    = r_seq_done;
        w_timeout_err = r_timeout_err;

        if (w_lock_lost || sw_rst) begin
            w_state     = WAIT_LOCK;
            w_cnt       = '0;
            w_stage_rst = ALL_ONES;
            w_stage_idx = 3'd0;
            w_seq_done  = 1'b0;
            if (!w_lock_lost) begin
                w_timeout_err = 1'b0;
            end
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_stage_rst = ALL_ONES;
                    w_stage_idx = 3'd0;
                    w_seq_done  = 1'b0;
                    if (w_lock_s) begin
                        w_state = DELAY;
                        w_cnt   = DLY_LOAD;
                    end
                end

                DELAY: begin
                    if (r_cnt == '0) begin
                        w_stage_rst = r_stage_rst & ~w_idx_mask;
                        w_cnt       = TMO_LOAD;
                        w_state     = WAIT_DONE;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end

                // An acknowledgement on the expiry edge still counts.
                WAIT_DONE: begin
                    if (w_done_sel) begin
                        if (r_stage_idx == LAST_IDX) begin
                            w_state    = RUN;
                            w_seq_done = 1'b1;
                        end else begin
                            w_stage_idx = r_stage_idx + 3'd1;
                            w_cnt       = DLY_LOAD;
                            w_state     = DELAY;
                        end
                    end else if (r_cnt == '0) begin
                        w_state       = ERR;
                        w_stage_rst   = ALL_ONES;
                        w_seq_done    = 1'b0;
                        w_timeout_err = 1'b1;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end

                RUN: begin
                    w_stage_rst = '0;
                    w_seq_done  = 1'b1;
                end

                ERR: begin
                    w_stage_rst   = ALL_ONES;
                    w_seq_done    = 1'b0;
                    w_timeout_err = 1'b1;
                end

                default: begin
                    w_state     = WAIT_LOCK;
                    w_stage_rst = ALL_ONES;
                    w_stage_idx = 3'd0;
                    w_seq_done  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= WAIT_LOCK;
            r_cnt         <= '0;
            r_stage_rst   <= ALL_ONES;
            r_stage_idx   <= 3'd0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_stage_rst   <= w_stage_rst;
            r_stage_idx   <= w_stage_idx;
            r_seq_done    <= w_seq_done;
            r_timeout_err <= w_timeout_err;
        end
    end

    assign stage_rst   = r_stage_rst;
    assign stage_idx   = r_stage_idx;
    assign seq_done    = r_seq_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_reset_seq
// Self-checking bench for reset_seq (NUM_STAGES=4, STAGE_DLY=4, TIMEOUT=10).
// A behavioural model tracks which phase the sequence is in and how many
// edges it has spent there; expected outputs are derived from that.
// ---------------------------------------------------------------------------
module tb_reset_seq;

    localparam int NS  = 4;
    localparam int DLY = 4;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          lock;
    logic          sw_rst;
    logic [NS-1:0] init_done;
    logic [NS-1:0] stage_rst;
    logic [2:0]    stage_idx;
    logic          seq_done;
    logic          timeout_err;

    always #5 clk = ~clk;

    reset_seq #(
        .NUM_STAGES (NS),
        .STAGE_DLY  (DLY),
        .TIMEOUT    (TMO),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lock        (lock),
        .sw_rst      (sw_rst),
        .init_done   (init_done),
        .stage_rst   (stage_rst),
        .stage_idx   (stage_idx),
        .seq_done    (seq_done),
        .timeout_err (timeout_err)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: phase, stage being worked on, edges spent in the phase.
    localparam int P_IDLE = 0, P_DELAY = 1, P_WAIT = 2, P_RUN = 3, P_ERR = 4;
    int mPhase, mStage, mAge;
    bit mErr;
    bit lockLast, lockPrev;

    // Init-done responder: stage k acknowledges respDelay[k] edges after
    // its reset is seen low, unless holdLow[k] is set.
    bit autoResp;
    bit holdLow[NS];
    int respDelay[NS];
    int relCnt[NS];

    typedef struct {
        int         edgeNo;
        logic       lockIn;
        logic [3:0] expRst;
        logic       expDone;
        logic [2:0] expIdx;
    } vec_t;

    vec_t nomTab[$];

    function automatic void modelReset();
        mPhase   = P_IDLE;
        mStage   = 0;
        mAge     = 0;
        mErr     = 1'b0;
        lockLast = 1'b0;
        lockPrev = 1'b0;
    endfunction

    // The synchronized lock seen at an edge is the raw lock sampled two
    // edges earlier.
    function automatic void modelStep();
        bit lockS;
        lockS = lockPrev;
        if (!lockS && (mPhase == P_DELAY || mPhase == P_WAIT || mPhase == P_RUN)) begin
            mPhase = P_IDLE; mStage = 0; mAge = 0;
        end else if (sw_rst) begin
            mPhase = P_IDLE; mStage = 0; mAge = 0; mErr = 1'b0;
        end else begin
            case (mPhase)
                P_IDLE: if (lockS) begin mPhase = P_DELAY; mAge = 0; end
                P_DELAY: begin
                    mAge++;
                    if (mAge == DLY) begin mPhase = P_WAIT; mAge = 0; end
                end
                P_WAIT: begin
                    mAge++;
                    if (init_done[mStage]) begin
                        if (mStage == NS - 1) mPhase = P_RUN;
                        else begin mStage++; mPhase = P_DELAY; mAge = 0; end
                    end else if (mAge == TMO) begin
                        mPhase = P_ERR; mErr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        lockPrev = lockLast;
        lockLast = lock;
    endfunction

    function automatic logic [3:0] mExpRst();
        case (mPhase)
            P_DELAY: return 4'(4'hF << mStage);
            P_WAIT:  return 4'(4'hF << (mStage + 1));
            P_RUN:   return 4'h0;
            default: return 4'hF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("stage_rst", 32'(stage_rst), 32'(mExpRst()));
        check("stage_idx", 32'(stage_idx), 32'(mStage));
        check("seq_done", 32'(seq_done), 32'(mPhase == P_RUN));
        check("timeout_err", 32'(timeout_err), 32'(mErr));
    endtask

    // One clock edge: advance the model, compare, then update the responder.
    task automatic tick();
        @(posedge clk);
        if (rst) modelReset();
        else modelStep();
        #1;
        checkOutput();
        if (autoResp) begin
            for (int k = 0; k < NS; k++) begin
                if (stage_rst[k] == 1'b0) relCnt[k]++;
                else relCnt[k] = 0;
                init_done[k] = !holdLow[k] && (relCnt[k] >= respDelay[k]);
            end
        end
    endtask

    function automatic bit cond(input int what);
        case (what)
            0: return stage_rst == 4'hF;
            1: return stage_rst[0] == 1'b0;
            2: return seq_done == 1'b1;
            3: return timeout_err == 1'b1;
            4: return stage_idx == 3'd2;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait; n is the 0-based index of the first edge meeting the
    // condition, or -1 if the budget ran out.
    task automatic runUntil(input int what, output int n);
        n = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cond(what)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus();
        rst       = 1'b1;
        lock      = 1'b0;
        sw_rst    = 1'b0;
        init_done = '0;
        autoResp  = 1'b1;
        for (int k = 0; k < NS; k++) begin
            holdLow[k]   = 1'b0;
            respDelay[k] = 2;
            relCnt[k]    = 0;
        end
        modelReset();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    int n;
    int row;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values before any clock edge.
        rst = 1'b1; lock = 1'b0; sw_rst = 1'b0; init_done = '0;
        autoResp = 1'b1;
        for (int k = 0; k < NS; k++) begin holdLow[k] = 0; respDelay[k] = 2; relCnt[k] = 0; end
        modelReset();
        #2;
        check("reset stage_rst", 32'(stage_rst), 32'hF);
        check("reset seq_done", 32'(seq_done), 32'h0);
        check("reset timeout_err", 32'(timeout_err), 32'h0);
        check("reset stage_idx", 32'(stage_idx), 32'h0);

        // Nominal run: checkpoints derived by hand, edge 0 is the first edge
        // with lock high; each stage acknowledges 2 edges after release.
        nomTab.push_back('{1,  1'b1, 4'b1111, 1'b0, 3'd0});
        nomTab.push_back('{2,  1'b1, 4'b1111, 1'b0, 3'd0});
        nomTab.push_back('{5,  1'b1, 4'b1111, 1'b0, 3'd0});
        nomTab.push_back('{6,  1'b1, 4'b1110, 1'b0, 3'd0});
        nomTab.push_back('{8,  1'b1, 4'b1110, 1'b0, 3'd1});
        nomTab.push_back('{11, 1'b1, 4'b1110, 1'b0, 3'd1});
        nomTab.push_back('{12, 1'b1, 4'b1100, 1'b0, 3'd1});
        nomTab.push_back('{14, 1'b1, 4'b1100, 1'b0, 3'd2});
        nomTab.push_back('{18, 1'b1, 4'b1000, 1'b0, 3'd2});
        nomTab.push_back('{20, 1'b1, 4'b1000, 1'b0, 3'd3});
        nomTab.push_back('{24, 1'b1, 4'b0000, 1'b0, 3'd3});
        nomTab.push_back('{25, 1'b1, 4'b0000, 1'b0, 3'd3});
        nomTab.push_back('{26, 1'b1, 4'b0000, 1'b1, 3'd3});
        nomTab.push_back('{30, 1'b1, 4'b0000, 1'b1, 3'd3});

        applyStimulus();
        row = 0;
        for (int e = 0; e <= 30; e++) begin
            lock = nomTab[row < nomTab.size() ? row : nomTab.size() - 1].lockIn;
            tick();
            if (row < nomTab.size() && nomTab[row].edgeNo == e) begin
                check($sformatf("nominal e%0d stage_rst", e), 32'(stage_rst), 32'(nomTab[row].expRst));
                check($sformatf("nominal e%0d seq_done", e), 32'(seq_done), 32'(nomTab[row].expDone));
                check($sformatf("nominal e%0d stage_idx", e), 32'(stage_idx), 32'(nomTab[row].expIdx));
                row++;
            end
        end
        check("nominal rows reached", 32'(row), 32'(nomTab.size()));

        // Lock loss in RUN for 5 edges, then the whole sequence repeats.
        lock = 1'b0;
        runUntil(0, n);
        check("lockloss edges to reset", 32'(n), 32'd2);
        check("lockloss seq_done", 32'(seq_done), 32'h0);
        tick();
        tick();
        lock = 1'b1;
        runUntil(1, n);
        check("relock stage0 release edge", 32'(n), 32'd6);
        runUntil(2, n);
        check("relock seq_done edge", 32'(n), 32'd19);

        // Timeout on stage 2: released at edge 18, error at edge 28.
        applyStimulus();
        holdLow[2] = 1'b1;
        lock = 1'b1;
        runUntil(3, n);
        check("timeout edge", 32'(n), 32'd28);
        check("timeout stage_rst", 32'(stage_rst), 32'hF);
        check("timeout stage_idx", 32'(stage_idx), 32'd2);
        for (int i = 0; i < 8; i++) begin
            lock = (i % 3 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        lock = 1'b1;
        tick();
        tick();
        check("err sticky with lock toggle", 32'(timeout_err), 32'h1);
        check("err idx frozen", 32'(stage_idx), 32'd2);

        // sw_rst from ERR with lock held high.
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check("sw_rst clears err", 32'(timeout_err), 32'h0);
        runUntil(1, n);
        check("sw_rst stage0 release edge", 32'(n), 32'd4);

        // Stage 1 acknowledges on the 10th WAIT_DONE edge: done wins.
        applyStimulus();
        respDelay[1] = 10;
        lock = 1'b1;
        runUntil(4, n);
        check("coincide advance edge", 32'(n), 32'd22);
        check("coincide no err", 32'(timeout_err), 32'h0);

        // One edge later is too late.
        applyStimulus();
        respDelay[1] = 11;
        lock = 1'b1;
        runUntil(3, n);
        check("late ack err edge", 32'(n), 32'd22);
        check("late ack idx", 32'(stage_idx), 32'd1);

        // Async rst in the middle of stage 2's DELAY.
        applyStimulus();
        lock = 1'b1;
        for (int e = 0; e <= 16; e++) tick();
        check("pre-async idx", 32'(stage_idx), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async stage_rst", 32'(stage_rst), 32'hF);
        check("async stage_idx", 32'(stage_idx), 32'h0);
        check("async seq_done", 32'(seq_done), 32'h0);
        check("async timeout_err", 32'(timeout_err), 32'h0);
        modelReset();
        tick();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        autoResp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            lock   = ($urandom_range(0, 99) >= 3);
            sw_rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NS; k++)
                init_done[k] = ($urandom_range(0, 99) < ((i < 1500) ? 25 : 8));
            tick();
        end
        sw_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
